mem_dump_ctrl: RTL and testbench
================================

Name: mem_dump_ctrl

Overview:
- Debug sequencer for the data-memory stage.
- Once the pipeline is halted and a start pulse arrives, it takes over the memory address and debug-select path and reads data memory words 0..NUM_WORDS-1 in order.
- Each word is serialised into bytes and streamed to the debug UART transmitter over a valid/ready handshake.
- When the dump completes, it releases the memory back to the ALU path.

Parameters:
- NB_DATA, 32, data memory word width; must be a multiple of 8.
- NB_ADDR, 7, data memory address width.
- NUM_WORDS, 128, number of words dumped per request; range 1..2^NB_ADDR.
- READ_LAT, 1, cycles from address/enable to valid memory read data; range 1..3.

Ports:
- clock_i, input, 1, system clock; all logic is rising-edge.
- reset_i, input, 1, synchronous active-high reset.
- start_dump_i, input, 1, single-cycle dump request.
- pipeline_halted_i, input, 1, high while the pipeline is stalled by the debug unit.
- data_read_i, input, NB_DATA, memory read data returned by the memory stage.
- tx_ready_i, input, 1, UART transmitter can accept a byte.
- select_debug_o, output, 1, high selects the debug address and forces read signalling in the memory stage.
- addr_mem_debug_o, output, NB_ADDR, debug word address.
- en_mem_o, output, 1, memory enable while the controller owns memory.
- tx_byte_o, output, 8, byte to transmit.
- tx_valid_o, output, 1, tx_byte_o is valid.
- busy_o, output, 1, dump in progress.
- done_o, output, 1, single-cycle pulse when the final byte is accepted.

Behaviour:
- Reset (synchronous, reset_i high at a clock edge):
  - All outputs go to 0.
  - FSM goes to IDLE; address counter, byte counter, latency counter and word latch clear.
  - Reset mid-dump aborts immediately; no further bytes are sent and select_debug_o drops on the same edge.
- FSM states: IDLE, READ, WAIT, SEND, NEXT, (CSUM).
- IDLE:
  - start_dump_i && pipeline_halted_i → READ, with addr = 0 and busy_o = 1.
  - start_dump_i while not halted is ignored, with no latching.
- READ:
  - Drives select_debug_o = 1, en_mem_o = 1 and addr_mem_debug_o = current address.
  - Loads the latency counter with READ_LAT-1 and goes to WAIT.
- WAIT:
  - Counts down; at 0, latches data_read_i into the word register, sets byte index = 0 and goes to SEND.
  - The latch happens exactly READ_LAT cycles after entering READ.
- SEND:
  - tx_valid_o = 1 and tx_byte_o = latched word byte, most significant byte first (byte index 0 = bits [NB_DATA-1 -: 8]).
  - A byte is consumed only on a cycle where tx_valid_o && tx_ready_i.
  - tx_byte_o stays stable while tx_ready_i is low; stalls are unbounded.
  - After byte NB_DATA/8-1 is accepted, go to NEXT.
- NEXT:
  - If address == NUM_WORDS-1: go to IDLE (or CSUM if enabled), pulse done_o, clear busy_o and drop select_debug_o.
  - Otherwise: address+1 and go to READ.
  - The counter is NB_ADDR+1 bits wide internally, so NUM_WORDS = 2^NB_ADDR terminates at 127 without wrapping to 0.
- Ownership:
  - select_debug_o and en_mem_o stay high from READ through NEXT of every word; there are no gaps between words.
  - select_debug_o is 0 in IDLE.
- Simultaneous events:
  - start_dump_i while busy_o is ignored.
  - pipeline_halted_i deasserting mid-dump does not abort the dump; the debug unit owns the halt.
  - start_dump_i on the same cycle as done_o is ignored, because the FSM is not yet in IDLE.
- Throughput: with tx_ready_i held high, one word takes READ_LAT + 1 + NB_DATA/8 + 1 cycles.

Optional Feature:
- DUMP_CHECKSUM_EN defined:
  - An 8-bit XOR accumulator clears at dump start and XORs in every accepted byte.
  - After the last word, the FSM enters CSUM and sends one extra byte (the accumulator) with the same handshake.
  - done_o pulses when that checksum byte is accepted.
  - select_debug_o drops when CSUM is entered.
- DUMP_CHECKSUM_EN undefined: no CSUM state and no accumulator; behaviour is exactly as described above.

Test Plan:
- Reset then idle, start_dump_i = 1 with pipeline_halted_i = 0 → busy_o, select_debug_o and tx_valid_o stay 0 for 20 cycles.
- Halted, NUM_WORDS = 2, memory word0 = 0x11223344, word1 = 0xAABBCCDD, tx_ready_i = 1 → bytes 11,22,33,44,AA,BB,CC,DD in order; addr_mem_debug_o shows 0 then 1; done_o pulses once on the DD acceptance.
- Same dump with tx_ready_i toggling 0/1 every 3 cycles → identical byte sequence; tx_byte_o is stable during every stall cycle.
- NUM_WORDS = 128, memory[i] = i → 512 bytes; the last address issued is 127, with no address-0 access after 127; busy_o falls after the final byte.
- Assert reset_i for one cycle during byte 2 of word 5 → next cycle all outputs 0; a fresh start restarts at address 0 with byte 0x00 of word 0.
- With DUMP_CHECKSUM_EN defined, the 2-word dump above → ninth byte = 0x11^0x22^0x33^0x44^0xAA^0xBB^0xCC^0xDD = 0x44; done_o pulses on that byte's acceptance.

Source files
------------

// File: rtl/mem_dump_ctrl.sv
// rtl/mem_dump_ctrl.sv - data-memory dump sequencer streaming words MSB-byte first; `DUMP_CHECKSUM_EN adds a trailing XOR byte
`timescale 1ns/1ps
module mem_dump_ctrl #(
    parameter int NB_DATA   = 32,
    parameter int NB_ADDR   = 7,
    parameter int NUM_WORDS = 128,
    parameter int READ_LAT  = 1
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               start_dump_i,
    input  logic               pipeline_halted_i,
    input  logic [NB_DATA-1:0] data_read_i,
    input  logic               tx_ready_i,
    output logic               select_debug_o,
    output logic [NB_ADDR-1:0] addr_mem_debug_o,
    output logic               en_mem_o,
    output logic [7:0]         tx_byte_o,
    output logic               tx_valid_o,
    output logic               busy_o,
    output logic               done_o
);

    localparam int NB_BYTES = NB_DATA / 8;
    localparam int BI_W     = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_READ = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_SEND = 3'd3;
    localparam logic [2:0] ST_NEXT = 3'd4;
`ifdef DUMP_CHECKSUM_EN
    localparam logic [2:0] ST_CSUM = 3'd5;
`endif

    // One extra address bit so NUM_WORDS = 2^NB_ADDR ends at the top address without wrapping
    localparam logic [NB_ADDR:0] LAST_ADDR = (NB_ADDR+1)'(NUM_WORDS - 1);
    localparam logic [NB_ADDR:0] ADDR_ONE  = (NB_ADDR+1)'(1);
    localparam logic [1:0]       LAT_INIT  = 2'(READ_LAT - 1);
    localparam logic [BI_W-1:0]  LAST_BYTE = BI_W'(NB_BYTES - 1);
    localparam logic [BI_W-1:0]  BYTE_ONE  = BI_W'(1);

    logic [2:0]         state_q, state_d;
    logic [NB_ADDR:0]   addr_q, addr_d;
    logic [BI_W-1:0]    byte_idx_q, byte_idx_d;
    logic [1:0]         lat_cnt_q, lat_cnt_d;
    logic [NB_DATA-1:0] word_q, word_d;
`ifdef DUMP_CHECKSUM_EN
    logic [7:0]         csum_q, csum_d;
`endif
    logic               own_mem;

    // Register update with synchronous reset; reset aborts any dump in flight
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            byte_idx_q <= '0;
            lat_cnt_q  <= '0;
            word_q     <= '0;
`ifdef DUMP_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            byte_idx_q <= byte_idx_d;
            lat_cnt_q  <= lat_cnt_d;
            word_q     <= word_d;
`ifdef DUMP_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    // Sequencer: read a word, wait out memory latency, shift bytes out, advance
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        byte_idx_d = byte_idx_q;
        lat_cnt_d  = lat_cnt_q;
        word_d     = word_q;
`ifdef DUMP_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_dump_i && pipeline_halted_i) begin
                    state_d = ST_READ;
                    addr_d  = '0;
`ifdef DUMP_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            ST_READ: begin
                lat_cnt_d = LAT_INIT;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                if (lat_cnt_q == 2'd0) begin
                    word_d     = data_read_i;
                    byte_idx_d = '0;
                    state_d    = ST_SEND;
                end else begin
                    lat_cnt_d = lat_cnt_q - 2'd1;
                end
            end
            ST_SEND: begin
                // tx_valid_o is high throughout SEND, so ready alone marks acceptance
                if (tx_ready_i) begin
                    word_d = word_q << 8;
`ifdef DUMP_CHECKSUM_EN
                    csum_d = csum_q ^ word_q[NB_DATA-1 -: 8];
`endif
                    if (byte_idx_q == LAST_BYTE) begin
                        state_d = ST_NEXT;
                    end else begin
                        byte_idx_d = byte_idx_q + BYTE_ONE;
                    end
                end
            end
            ST_NEXT: begin
                if (addr_q == LAST_ADDR) begin
                    addr_d = '0;
`ifdef DUMP_CHECKSUM_EN
                    state_d = ST_CSUM;
`else
                    state_d = ST_IDLE;
`endif
                end else begin
                    addr_d  = addr_q + ADDR_ONE;
                    state_d = ST_READ;
                end
            end
`ifdef DUMP_CHECKSUM_EN
            ST_CSUM: begin
                if (tx_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode straight from state so reset clears every output on the same edge
    always_comb begin
        own_mem          = (state_q == ST_READ) || (state_q == ST_WAIT) ||
                           (state_q == ST_SEND) || (state_q == ST_NEXT);
        select_debug_o   = own_mem;
        en_mem_o         = own_mem;
        addr_mem_debug_o = own_mem ? addr_q[NB_ADDR-1:0] : '0;
        busy_o           = (state_q != ST_IDLE);
        tx_valid_o       = (state_q == ST_SEND);
        tx_byte_o        = (state_q == ST_SEND) ? word_q[NB_DATA-1 -: 8] : 8'h00;
`ifdef DUMP_CHECKSUM_EN
        if (state_q == ST_CSUM) begin
            tx_valid_o = 1'b1;
            tx_byte_o  = csum_q;
        end
        done_o           = (state_q == ST_CSUM) && tx_ready_i;
`else
        done_o           = (state_q == ST_NEXT) && (addr_q == LAST_ADDR);
`endif
    end

endmodule

// File: tb/tb_mem_dump_ctrl.sv
// tb/tb_mem_dump_ctrl.sv - directed self-checking bench for mem_dump_ctrl (2-word and 128-word instances)
`timescale 1ns/1ps
module tb_mem_dump_ctrl;

`ifdef DUMP_CHECKSUM_EN
    localparam int CSUM = 1;
`else
    localparam int CSUM = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, start_a = 1'b0, start_b = 1'b0, halted = 1'b0, ready = 1'b0;
    logic [31:0] rd_a = '0, rd_b = '0;
    logic        sel_a, en_a, valid_a, busy_a, done_a;
    logic        sel_b, en_b, valid_b, busy_b, done_b;
    logic [6:0]  addr_a, addr_b;
    logic [7:0]  byte_a, byte_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    mem_dump_ctrl #(.NB_DATA(32), .NB_ADDR(7), .NUM_WORDS(2), .READ_LAT(1)) dut_a (
        .clock_i(clk), .reset_i(rst), .start_dump_i(start_a), .pipeline_halted_i(halted),
        .data_read_i(rd_a), .tx_ready_i(ready), .select_debug_o(sel_a),
        .addr_mem_debug_o(addr_a), .en_mem_o(en_a), .tx_byte_o(byte_a),
        .tx_valid_o(valid_a), .busy_o(busy_a), .done_o(done_a));

    mem_dump_ctrl #(.NB_DATA(32), .NB_ADDR(7), .NUM_WORDS(128), .READ_LAT(1)) dut_b (
        .clock_i(clk), .reset_i(rst), .start_dump_i(start_b), .pipeline_halted_i(halted),
        .data_read_i(rd_b), .tx_ready_i(ready), .select_debug_o(sel_b),
        .addr_mem_debug_o(addr_b), .en_mem_o(en_b), .tx_byte_o(byte_b),
        .tx_valid_o(valid_b), .busy_o(busy_b), .done_o(done_b));

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous memories with one cycle of read latency
    always @(posedge clk) begin
        rd_a <= addr_a[0] ? 32'hAABBCCDD : 32'h11223344;
        rd_b <= {25'd0, addr_b};
    end

    logic [7:0] acc_a[$];
    logic [7:0] acc_b[$];
    logic [6:0] adr_a[$];
    logic [6:0] adr_b[$];
    int         last_acc_a = 0, done_cnt_a = 0, done_cyc_a = 0, busy_cyc_a = 0, stall_err_a = 0;
    int         done_cnt_b = 0;
    logic       pv_a = 1'b0, pr_a = 1'b0, pen_a = 1'b0, pen_b = 1'b0;
    logic [7:0] pb_a = '0;
    logic [6:0] padr_a = '0, padr_b = '0;

    always @(negedge clk) begin
        if (valid_a && ready) begin
            acc_a.push_back(byte_a);
            last_acc_a <= cyc;
        end
        if (pv_a && !pr_a && (!valid_a || byte_a !== pb_a)) stall_err_a <= stall_err_a + 1;
        if (en_a && (!pen_a || addr_a != padr_a)) adr_a.push_back(addr_a);
        if (done_a) begin
            done_cnt_a <= done_cnt_a + 1;
            done_cyc_a <= cyc;
        end
        if (busy_a) busy_cyc_a <= busy_cyc_a + 1;
        pv_a   <= valid_a;
        pr_a   <= ready;
        pb_a   <= byte_a;
        pen_a  <= en_a;
        padr_a <= addr_a;
    end

    always @(negedge clk) begin
        if (valid_b && ready) acc_b.push_back(byte_b);
        if (en_b && (!pen_b || addr_b != padr_b)) adr_b.push_back(addr_b);
        if (done_b) done_cnt_b <= done_cnt_b + 1;
        pen_b  <= en_b;
        padr_b <= addr_b;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({sel_a, en_a, valid_a, busy_a, done_a} !== 5'b0)
            begin errors++; $display("FAIL reset_ctrl_a: got %b want 00000", {sel_a, en_a, valid_a, busy_a, done_a}); end
        checks++;
        if ({byte_a, addr_a} !== 15'b0)
            begin errors++; $display("FAIL reset_data_a: got %h/%h want 00/00", byte_a, addr_a); end
        rst = 1'b0;
        tick();
        checks++;
        if ({sel_b, en_b, valid_b, busy_b, done_b, byte_b, addr_b} !== 20'b0)
            begin errors++; $display("FAIL reset_b: got %h want 0", {sel_b, en_b, valid_b, busy_b, done_b, byte_b, addr_b}); end
    endtask

    task automatic test_not_halted();
        halted  = 1'b0;
        start_a = 1'b1;
        start_b = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if ({busy_a, sel_a, valid_a, busy_b, sel_b, valid_b} !== 6'b0)
                begin errors++; $display("FAIL not_halted cycle %0d: got %b want 000000", i, {busy_a, sel_a, valid_a, busy_b, sel_b, valid_b}); end
        end
        start_a = 1'b0;
        start_b = 1'b0;
        halted  = 1'b1;
        repeat (3) tick();
        checks++;
        if ({busy_a, busy_b} !== 2'b00)
            begin errors++; $display("FAIL no_latch: busy got %b want 00", {busy_a, busy_b}); end
    endtask

    task automatic test_two_word(input bit stall);
        logic [7:0] exp [9];
        int b0, a0, d0, bc0, s0, k, n;
        exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h44};
        b0 = acc_a.size(); a0 = adr_a.size(); d0 = done_cnt_a; bc0 = busy_cyc_a; s0 = stall_err_a;
        halted  = 1'b1;
        ready   = !stall;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        k = 0;
        while (k < 400) begin
            if (stall) ready = ((k / 3) % 2) == 1;
            tick();
            k++;
            if (!busy_a) break;
        end
        ready = 1'b1;
        tick();
        checks++;
        if (k >= 400) begin errors++; $display("FAIL two_word_timeout stall=%0d: busy still %b after %0d cycles", stall, busy_a, k); end
        n = acc_a.size() - b0;
        checks++;
        if (n != 8 + CSUM) begin errors++; $display("FAIL two_word_count stall=%0d: got %0d want %0d", stall, n, 8 + CSUM); end
        for (int i = 0; i < 8 + CSUM && i < n; i++) begin
            checks++;
            if (acc_a[b0+i] !== exp[i])
                begin errors++; $display("FAIL two_word_byte%0d stall=%0d: got %h want %h", i, stall, acc_a[b0+i], exp[i]); end
        end
        checks++;
        if (adr_a.size() - a0 != 2 || adr_a[a0] !== 7'd0 || adr_a[a0+1] !== 7'd1)
            begin errors++; $display("FAIL two_word_addr stall=%0d: got %0d addresses, first %0d", stall, adr_a.size() - a0, adr_a[a0]); end
        checks++;
        if (done_cnt_a - d0 != 1) begin errors++; $display("FAIL two_word_done_cnt stall=%0d: got %0d want 1", stall, done_cnt_a - d0); end
        checks++;
        if (done_cyc_a != last_acc_a + 1 - CSUM)
            begin errors++; $display("FAIL two_word_done_timing stall=%0d: done cycle %0d, last accept %0d", stall, done_cyc_a, last_acc_a); end
        if (stall) begin
            checks++;
            if (stall_err_a != s0) begin errors++; $display("FAIL stall_stable: got %0d unstable cycles want 0", stall_err_a - s0); end
        end else begin
            checks++;
            if (busy_cyc_a - bc0 != 14 + CSUM)
                begin errors++; $display("FAIL two_word_busy_cycles: got %0d want %0d", busy_cyc_a - bc0, 14 + CSUM); end
        end
    endtask

    task automatic test_full_dump();
        int b0, a0, d0, k, n, bad, first_bad, na, zero_after;
        logic [7:0] expb, xsum;
        b0 = acc_b.size(); a0 = adr_b.size(); d0 = done_cnt_b;
        ready   = 1'b1;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        k = 0;
        while (k < 1200 && busy_b) begin tick(); k++; end
        tick();
        checks++;
        if (k >= 1200) begin errors++; $display("FAIL full_timeout: busy still %b", busy_b); end
        n = acc_b.size() - b0;
        checks++;
        if (n != 512 + CSUM) begin errors++; $display("FAIL full_count: got %0d want %0d", n, 512 + CSUM); end
        bad = 0; first_bad = -1; xsum = 8'h00;
        for (int i = 0; i < 512 && i < n; i++) begin
            expb = ((i % 4) == 3) ? 8'(i / 4) : 8'h00;
            xsum = xsum ^ expb;
            if (acc_b[b0+i] !== expb) begin bad++; if (first_bad < 0) first_bad = i; end
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL full_bytes: %0d wrong, first at byte %0d", bad, first_bad); end
        na = adr_b.size() - a0;
        zero_after = 0;
        for (int i = 1; i < na; i++) if (adr_b[a0+i] == 7'd0) zero_after++;
        checks++;
        if (na != 128 || adr_b[a0+na-1] !== 7'd127 || zero_after != 0)
            begin errors++; $display("FAIL full_addr: got %0d addresses, last %0d, %0d late zero accesses; want 128, 127, 0", na, adr_b[a0+na-1], zero_after); end
        checks++;
        if (busy_b !== 1'b0 || sel_b !== 1'b0 || done_cnt_b - d0 != 1)
            begin errors++; $display("FAIL full_end: busy %b sel %b done pulses %0d; want 0 0 1", busy_b, sel_b, done_cnt_b - d0); end
`ifdef DUMP_CHECKSUM_EN
        checks++;
        if (n > 512 && acc_b[b0+512] !== xsum)
            begin errors++; $display("FAIL full_csum: got %h want %h", acc_b[b0+512], xsum); end
`endif
    endtask

    task automatic test_reset_mid();
        int b0, a0, k, d0;
        b0 = acc_b.size();
        ready   = 1'b1;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        k = 0;
        while (k < 300 && acc_b.size() - b0 != 22) begin tick(); k++; end
        checks++;
        if (k >= 300) begin errors++; $display("FAIL mid_reach: got %0d bytes want 22", acc_b.size() - b0); end
        rst   = 1'b1;
        ready = 1'b0;
        tick();
        rst = 1'b0;
        checks++;
        if ({sel_b, en_b, valid_b, busy_b, done_b, byte_b, addr_b} !== 20'b0)
            begin errors++; $display("FAIL mid_reset_outputs: got %h want 0", {sel_b, en_b, valid_b, busy_b, done_b, byte_b, addr_b}); end
        ready = 1'b1;
        repeat (3) tick();
        checks++;
        if (acc_b.size() - b0 != 22) begin errors++; $display("FAIL mid_no_more_bytes: got %0d want 22", acc_b.size() - b0); end
        b0 = acc_b.size(); a0 = adr_b.size(); d0 = done_cnt_b;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        k = 0;
        while (k < 1200 && busy_b) begin tick(); k++; end
        tick();
        checks++;
        if (adr_b.size() <= a0 || adr_b[a0] !== 7'd0)
            begin errors++; $display("FAIL restart_addr: got %0d want 0", (adr_b.size() > a0) ? adr_b[a0] : 7'h7f); end
        checks++;
        if (acc_b.size() - b0 < 8 || {acc_b[b0], acc_b[b0+1], acc_b[b0+2], acc_b[b0+3]} !== 32'h0 ||
            {acc_b[b0+4], acc_b[b0+5], acc_b[b0+6], acc_b[b0+7]} !== 32'h1)
            begin errors++; $display("FAIL restart_bytes: got %0d bytes, first byte %h want 00", acc_b.size() - b0, acc_b[b0]); end
        checks++;
        if (acc_b.size() - b0 != 512 + CSUM || done_cnt_b - d0 != 1)
            begin errors++; $display("FAIL restart_complete: got %0d bytes, %0d done; want %0d, 1", acc_b.size() - b0, done_cnt_b - d0, 512 + CSUM); end
    endtask

    initial begin
        test_reset();
        test_not_halted();
        test_two_word(1'b0);
        test_two_word(1'b1);
        test_full_dump();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
